// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_e : transmitter FSM states
//   tx_sel_e   : Tx_out mux select (start=00, idle/stop=01, data=10, parity=11)
//   PARITY_*   : Parity_type encodings
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        SEL_START  = 2'b00,
        SEL_IDLE   = 2'b01,
        SEL_DATA   = 2'b10,
        SEL_PARITY = 2'b11
    } tx_sel_e;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write strobe and word (caller gates with ready)
//   pop        : read strobe (caller gates with !empty_c)
//   rdata_c    : head word, combinational
//   empty_c    : FIFO empty, combinational
//   ready      : registered not-full, derived from the next count
//   count      : stored words; extra bit separates full from empty
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata_c,
    output logic                          empty_c,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_n;

    assign count_n = count + CNT_W'(push) - CNT_W'(pop);
    assign empty_c = (count == '0);
    assign rdata_c = mem[rd_ptr];

    // Storage array needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_n;
            ready <= (count_n != CNT_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: programmable width, prescaler, parity, 1/2 stop bits.
//   CLK, Reset       : clock, async active-low reset
//   Data_valid/Data  : upstream word, accepted when Data_ready is high
//   Data_ready       : registered FIFO not-full
//   Parity_EN        : append parity bit; Parity_type 1=odd, 0=even
//   Stop2_EN         : two stop bits when set
//   Prescale         : CLK cycles per bit (0 acts as 1)
//   Tx_out           : registered serial line, idle high
//   Busy             : registered, frame in progress or FIFO non-empty
//   Fifo_count       : words currently stored
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          Data_valid,
    input  logic [DATA_WIDTH-1:0]         Data,
    output logic                          Data_ready,
    input  logic                          Parity_EN,
    input  logic                          Parity_type,
    input  logic                          Stop2_EN,
    input  logic [PRESCALE_W-1:0]         Prescale,
    output logic                          Tx_out,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    tx_state_e               state, state_n;
    logic [PRESCALE_W-1:0]   tick_cnt, tick_n;
    logic [IDX_W-1:0]        bit_idx, idx_n;
    logic [DATA_WIDTH-1:0]   shreg, shreg_n;
    logic                    par_bit, par_bit_n;
    logic                    par_en_q, par_en_n;
    logic                    stop2_q, stop2_n;
    logic [PRESCALE_W-1:0]   pres_q, pres_n;

    logic                    push_c;
    logic                    pop_c;
    logic                    load_c;
    logic                    bit_end_c;
    logic                    empty_c;
    logic [DATA_WIDTH-1:0]   head_c;
    logic [PRESCALE_W-1:0]   pres_eff_c;
    tx_sel_e                 sel_c;

    assign push_c     = Data_valid && Data_ready;
    assign pop_c      = load_c;
    assign bit_end_c  = (tick_cnt == '0);
    assign pres_eff_c = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (Reset),
        .push    (push_c),
        .wdata   (Data),
        .pop     (pop_c),
        .rdata_c (head_c),
        .empty_c (empty_c),
        .ready   (Data_ready),
        .count   (Fifo_count)
    );

    // Next-state, bit timing, shift register and mux select.
    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        idx_n     = bit_idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        par_en_n  = par_en_q;
        stop2_n   = stop2_q;
        pres_n    = pres_q;
        load_c    = 1'b0;
        sel_c     = SEL_IDLE;

        case (state)
            ST_IDLE: begin
                sel_c  = SEL_IDLE;
                load_c = !empty_c;
            end
            ST_START: begin
                sel_c = SEL_START;
                if (bit_end_c) begin
                    tick_n  = pres_q - PRESCALE_W'(1);
                    idx_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    tick_n = tick_cnt - PRESCALE_W'(1);
                end
            end
            ST_DATA: begin
                sel_c = SEL_DATA;
                if (bit_end_c) begin
                    tick_n  = pres_q - PRESCALE_W'(1);
                    shreg_n = shreg >> 1;
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_n   = '0;
                        state_n = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    tick_n = tick_cnt - PRESCALE_W'(1);
                end
            end
            ST_PARITY: begin
                sel_c = SEL_PARITY;
                if (bit_end_c) begin
                    tick_n  = pres_q - PRESCALE_W'(1);
                    idx_n   = '0;
                    state_n = ST_STOP;
                end else begin
                    tick_n = tick_cnt - PRESCALE_W'(1);
                end
            end
            ST_STOP: begin
                sel_c = SEL_IDLE;
                if (bit_end_c) begin
                    // bit_idx counts stop bits already completed
                    if (stop2_q && (bit_idx == '0)) begin
                        tick_n = pres_q - PRESCALE_W'(1);
                        idx_n  = IDX_W'(1);
                    end else if (!empty_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    tick_n = tick_cnt - PRESCALE_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Pop the head word and freeze the frame configuration.
        if (load_c) begin
            shreg_n   = head_c;
            par_bit_n = (Parity_type == PARITY_ODD) ? ~(^head_c) : (^head_c);
            par_en_n  = Parity_EN;
            stop2_n   = Stop2_EN;
            pres_n    = pres_eff_c;
            tick_n    = pres_eff_c - PRESCALE_W'(1);
            idx_n     = '0;
            state_n   = ST_START;
        end
    end

    // State, frame registers and registered line/busy outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            pres_q   <= PRESCALE_W'(1);
            Tx_out   <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_idx  <= idx_n;
            shreg    <= shreg_n;
            par_bit  <= par_bit_n;
            par_en_q <= par_en_n;
            stop2_q  <= stop2_n;
            pres_q   <= pres_n;
            Busy     <= (state != ST_IDLE) || (Fifo_count != '0);
            case (sel_c)
                SEL_START:  Tx_out <= 1'b0;
                SEL_DATA:   Tx_out <= shreg[0];
                SEL_PARITY: Tx_out <= par_bit;
                default:    Tx_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed scoreboard bench for uart_tx_fifo (8-bit and 5-bit instances).
module tb_uart_tx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 6;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Data_valid;
    logic [DW-1:0] Data;
    logic          Data_ready;
    logic          Parity_EN;
    logic          Parity_type;
    logic          Stop2_EN;
    logic [PW-1:0] Prescale;
    logic          Tx_out;
    logic          Busy;
    logic [2:0]    Fifo_count;

    logic          v5;
    logic [4:0]    d5;
    logic          r5;
    logic [PW-1:0] p5;
    logic          tx5;
    logic          busy5;
    logic [2:0]    cnt5;

    int checks = 0;
    int errors = 0;

    logic          exp_q[$];
    logic [DW-1:0] send_q[$];

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut8 (
        .CLK(CLK), .Reset(Reset), .Data_valid(Data_valid), .Data(Data),
        .Data_ready(Data_ready), .Parity_EN(Parity_EN), .Parity_type(Parity_type),
        .Stop2_EN(Stop2_EN), .Prescale(Prescale), .Tx_out(Tx_out), .Busy(Busy),
        .Fifo_count(Fifo_count)
    );

    uart_tx_fifo #(.DATA_WIDTH(5), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut5 (
        .CLK(CLK), .Reset(Reset), .Data_valid(v5), .Data(d5),
        .Data_ready(r5), .Parity_EN(Parity_EN), .Parity_type(Parity_type),
        .Stop2_EN(Stop2_EN), .Prescale(p5), .Tx_out(tx5), .Busy(busy5),
        .Fifo_count(cnt5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    task automatic add_frame(input logic [DW-1:0] w);
        int   p;
        logic bits[$];
        p = (Prescale == '0) ? 1 : int'(Prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) bits.push_back(w[i]);
        if (Parity_EN) bits.push_back(Parity_type ? ~(^w) : (^w));
        bits.push_back(1'b1);
        if (Stop2_EN) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j < p; j++) exp_q.push_back(bits[i]);
        end
    endtask

    // One clock: record handshake, score Tx_out, drive next word.
    task automatic cycle();
        logic acc;
        acc = Data_valid && Data_ready;
        @(negedge CLK);
        if (acc) begin
            // idle FSM: line stays high two more samples before the start bit
            if (exp_q.size() == 0) begin
                exp_q.push_back(1'b1);
                exp_q.push_back(1'b1);
            end
            add_frame(send_q.pop_front());
        end
        if (exp_q.size() > 0) chk("tx_bit", 32'(Tx_out), 32'(exp_q.pop_front()));
        Data_valid = (send_q.size() > 0);
        Data       = (send_q.size() > 0) ? send_q[0] : '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || send_q.size() > 0) && n < 3000) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 32'(exp_q.size() + send_q.size()), 32'd0);
        chk({tag, "_busy_last"}, 32'(Busy), 32'd1);
        cycle();
        chk({tag, "_busy_fall"}, 32'(Busy), 32'd0);
        chk({tag, "_count"}, 32'(Fifo_count), 32'd0);
    endtask

    initial begin
        logic exp5[$];
        Reset = 1'b0; Data_valid = 1'b0; Data = '0;
        Parity_EN = 1'b0; Parity_type = 1'b0; Stop2_EN = 1'b0; Prescale = PW'(1);
        v5 = 1'b0; d5 = '0; p5 = '0;

        // Values held while in reset
        @(negedge CLK);
        chk("rst_tx", 32'(Tx_out), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ready", 32'(Data_ready), 32'd1);
        chk("rst_count", 32'(Fifo_count), 32'd0);
        chk("rst_tx5", 32'(tx5), 32'd1);
        Reset = 1'b1;
        repeat (2) cycle();

        // Reset mid-frame aborts immediately
        Prescale = PW'(4);
        send_q.push_back(8'hA5);
        repeat (12) cycle();
        Reset = 1'b0;
        #1;
        chk("midrst_tx", 32'(Tx_out), 32'd1);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_ready", 32'(Data_ready), 32'd1);
        chk("midrst_count", 32'(Fifo_count), 32'd0);
        exp_q.delete();
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            chk("postrst_tx", 32'(Tx_out), 32'd1);
            chk("postrst_busy", 32'(Busy), 32'd0);
        end

        // Basic frame, prescale 1
        Prescale = PW'(1);
        send_q.push_back(8'hA5);
        drain("basic");
        repeat (3) cycle();

        // Parity even then odd, with Parity_type toggled mid-frame
        Prescale = PW'(2); Parity_EN = 1'b1; Parity_type = 1'b0;
        send_q.push_back(8'h03);
        drain("par_even");
        repeat (3) cycle();
        Parity_type = 1'b1;
        send_q.push_back(8'h03);
        repeat (6) cycle();
        Parity_type = 1'b0;
        drain("par_odd");
        repeat (3) cycle();

        // Two stop bits, back-to-back frames
        Parity_EN = 1'b0; Stop2_EN = 1'b1; Prescale = PW'(3);
        send_q.push_back(8'hFF);
        send_q.push_back(8'h00);
        drain("stop2");
        repeat (3) cycle();

        // FIFO full with valid held
        Stop2_EN = 1'b0; Prescale = PW'(8);
        for (int i = 0; i < 6; i++) send_q.push_back(DW'(8'h11 * (i + 1)));
        repeat (6) cycle();
        chk("full_ready", 32'(Data_ready), 32'd0);
        chk("full_count", 32'(Fifo_count), 32'd4);
        chk("full_pending", 32'(send_q.size()), 32'd1);
        repeat (20) cycle();
        chk("full_hold_ready", 32'(Data_ready), 32'd0);
        chk("full_hold_pending", 32'(send_q.size()), 32'd1);
        drain("full");
        repeat (3) cycle();

        // Prescale 0 acts as 1
        Prescale = '0;
        send_q.push_back(8'h5A);
        drain("pres0");
        repeat (3) cycle();

        // 5-bit instance, prescale 0
        exp5 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        v5 = 1'b1; d5 = 5'b10011;
        chk("w5_ready", 32'(r5), 32'd1);
        cycle();
        v5 = 1'b0; d5 = '0;
        foreach (exp5[i]) begin
            chk("w5_tx_bit", 32'(tx5), 32'(exp5[i]));
            if (i < exp5.size() - 1) cycle();
        end
        chk("w5_busy_last", 32'(busy5), 32'd1);
        cycle();
        chk("w5_busy_fall", 32'(busy5), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
